gsm_resp_rx: RTL and testbench
==============================

# gsm_resp_rx

UART receiver and response parser for the GSM modem link: deserialises 8N1 bytes from the modem TX pin, strips them into lines and reports the modem's final result codes (OK, ERROR) and the SMS text prompt (">"). It sits beside the AT-command transmitter. The transmitter pulses `cmd_sent` when a command's carriage return has left the wire, and this block either reports the outcome or flags a response timeout.

## Interface
- `CLKS_PER_BIT`, default 2500: clk cycles per UART bit (24 MHz / 9600 baud).
- `TIMEOUT_CLKS`, default 24000000: cycles allowed from `cmd_sent` to a result before `resp_timeout`.
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `line_rx` in 1: serial input from the modem; asynchronous; idles high.
- `cmd_sent` in 1: one-cycle pulse from the transmitter; arms the timeout.
- `rx_data` out 8: last received byte; valid while `rx_valid` is high and held until the next byte.
- `rx_valid` out 1: one-cycle pulse per correctly framed byte.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `rx_busy` out 1: high from start-bit detection until return to IDLE.
- `resp_ok` out 1: one-cycle pulse on a line equal to "OK".
- `resp_err` out 1: one-cycle pulse on a line equal to "ERROR".
- `resp_prompt` out 1: one-cycle pulse on ">" as the first character of a line.
- `resp_timeout` out 1: one-cycle pulse when the armed timer expires.

## Operation
- Reset values: `rx_data`=0x00, and all pulses and `rx_busy` are 0. The synchroniser flops are 1, the RX FSM is in IDLE, the parser is in LS, and the timer is disarmed and at 0.
- **Synchroniser:** `line_rx` passes through two flops, giving signal `rxs`. All logic uses `rxs`.
- **RX FSM** (bit counter 0..CLKS_PER_BIT-1, bit index 0..7):
  - IDLE: `rxs`=0 → START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1, sample `rxs`. 1 → IDLE (glitch rejected, no output). 0 → DATA, counter cleared.
  - DATA: at count CLKS_PER_BIT-1, shift `rxs` into bit[index], LSB first. After index 7 → STOP.
  - STOP: at count CLKS_PER_BIT-1, sample. 1 → load `rx_data`, pulse `rx_valid`, go IDLE. 0 → pulse `frame_err` and go BREAK; `rx_data` is unchanged.
  - BREAK: wait for `rxs`=1, then IDLE.
- **Parser**, advancing on `rx_valid` only. States: LS, O, OK, E, ER, ERR, ERRO, ERROR, SKIP.
  - CR (0x0D) or LF (0x0A) in any state: OK → pulse `resp_ok`; ERROR → pulse `resp_err`; next state LS in all cases.
  - LS: 'O' → O; 'E' → E; '>' → pulse `resp_prompt`, then SKIP; any other byte → SKIP.
  - Each matching state advances on the exact next uppercase letter. Any other non-terminator byte → SKIP.
  - SKIP holds until CR/LF.
  - Command echo (e.g. "AT+CSQ\r") therefore produces no pulse. "OKX\r" produces none.
- **Timeout timer:**
  - `cmd_sent` clears the count to 0 and arms the timer.
  - While armed, the count increments each cycle.
  - At TIMEOUT_CLKS-1: pulse `resp_timeout`, disarm, clear.
  - Any `resp_ok`/`resp_err`/`resp_prompt` disarms and clears.
  - `cmd_sent` coincident with a result pulse: `cmd_sent` wins (timer re-armed at 0).
  - Results that arrive while the timer is disarmed are still reported.
- `frame_err` does not affect the parser or the timer.

## Timing
- `rx_valid`/`frame_err` rise 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (±1) after the `line_rx` falling edge.
- Result pulses rise exactly 1 cycle after the `rx_valid` of the terminating byte (or of '>').
- A new start bit is accepted in the cycle after the stop-bit sample (back-to-back bytes, no idle gap required).
- The sample point is the bit centre, which tolerates ±4% baud mismatch.
- `rst_n` low mid-byte: on the next edge, all state returns to reset values, the partial byte is discarded, and no pulse is emitted. After release, a line already low is treated as a start bit.
- At most one of `rx_valid`/`frame_err` per frame. At most one result pulse per cycle.

## Test plan
- "OK\r\n" at CLKS_PER_BIT=16 → `rx_valid` ×4 with 0x4F, 0x4B, 0x0D, 0x0A. `resp_ok` pulses once, 1 cycle after the 0x0D `rx_valid`. No other result pulse.
- "AT\r\nERROR\r\n" → no pulse on the echo line. `resp_err` pulses once after the second 0x0D.
- "\r\n> " → `resp_prompt` 1 cycle after the '>' `rx_valid`. A later "X>\r" gives no prompt pulse.
- 0x41 sent with stop bit 0, line held low 3 bit-times, then "OK\r" → `frame_err` once, no `rx_valid` for 0x41, then `resp_ok` (parser unaffected). A 5-cycle low glitch yields nothing.
- TIMEOUT_CLKS=1000: `cmd_sent` with no traffic → `resp_timeout` exactly 1000 cycles later (±1). `cmd_sent` followed by "OK\r" within the window → `resp_ok` and no timeout. `cmd_sent` on the same cycle as `resp_ok` → timeout 1000 cycles later.
- `rst_n` low for 1 cycle mid-DATA of 0x55, then "OK\r" → outputs at reset values, no partial byte, one `resp_ok` for the new line.

Source files
------------

// File: rtl/gsm_resp_rx.sv
// gsm_resp_rx: 8N1 UART receiver for the GSM modem TX line, plus a line
// parser that reports OK / ERROR result codes and the SMS '>' prompt, and a
// response timer armed by the AT-command transmitter.
module gsm_resp_rx #(
  parameter int CLKS_PER_BIT = 2500,
  parameter int TIMEOUT_CLKS = 24000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_rx,
  input  logic       cmd_sent,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy,
  output logic       resp_ok,
  output logic       resp_err,
  output logic       resp_prompt,
  output logic       resp_timeout
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_GT = 8'h3E;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [3:0] {P_LS, P_O, P_OK, P_E, P_ER, P_ERR, P_ERRO, P_ERROR, P_SKIP} p_state_t;

  // ---------------- input synchroniser ----------------
  logic [1:0] sync_q, sync_d;
  logic       rxs;

  // Shift the asynchronous line through two flops before anything looks at it
  always_comb begin
    sync_d = {sync_q[0], line_rx};
  end

  // Synchroniser flops idle high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign rxs = sync_q[1];

  // ---------------- UART receive FSM ----------------
  rx_state_t     rx_state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, frame_err_q, rx_busy_q;

  // Mid-bit sampling receiver; the stop bit decides between a byte and a framing error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state_q <= RX_START;
            bit_cnt_q  <= '0;
            rx_busy_q  <= 1'b1;
          end
        end
        RX_START: begin
          if (bit_cnt_q == HALF_M1) begin
            bit_cnt_q <= '0;
            if (rxs) begin
              // Line went back high before mid start bit: treat as a glitch
              rx_state_q <= RX_IDLE;
              rx_busy_q  <= 1'b0;
            end else begin
              rx_state_q <= RX_DATA;
              bit_idx_q  <= '0;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt_q == FULL_M1) begin
            bit_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rxs;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                   bit_idx_q  <= bit_idx_q + 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt_q == FULL_M1) begin
            bit_cnt_q <= '0;
            if (rxs) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              rx_state_q <= RX_IDLE;
              rx_busy_q  <= 1'b0;
            end else begin
              // Keep the previous rx_data; wait out the break before re-arming
              frame_err_q <= 1'b1;
              rx_state_q  <= RX_BREAK;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rxs) begin
            rx_state_q <= RX_IDLE;
            rx_busy_q  <= 1'b0;
          end
        end
        default: begin
          rx_state_q <= RX_IDLE;
          rx_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- response line parser ----------------
  p_state_t p_state_q;
  logic     resp_ok_q, resp_err_q, resp_prompt_q;

  // Match whole lines against "OK"/"ERROR" and a leading '>'; anything else is skipped to the terminator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_state_q     <= P_LS;
      resp_ok_q     <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_prompt_q <= 1'b0;
    end else begin
      resp_ok_q     <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_prompt_q <= 1'b0;
      if (rx_valid_q) begin
        if (rx_data_q == CH_CR || rx_data_q == CH_LF) begin
          resp_ok_q  <= (p_state_q == P_OK);
          resp_err_q <= (p_state_q == P_ERROR);
          p_state_q  <= P_LS;
        end else begin
          case (p_state_q)
            P_LS: begin
              if (rx_data_q == CH_O)      p_state_q <= P_O;
              else if (rx_data_q == CH_E) p_state_q <= P_E;
              else begin
                resp_prompt_q <= (rx_data_q == CH_GT);
                p_state_q     <= P_SKIP;
              end
            end
            P_O:    p_state_q <= (rx_data_q == CH_K) ? P_OK    : P_SKIP;
            P_E:    p_state_q <= (rx_data_q == CH_R) ? P_ER    : P_SKIP;
            P_ER:   p_state_q <= (rx_data_q == CH_R) ? P_ERR   : P_SKIP;
            P_ERR:  p_state_q <= (rx_data_q == CH_O) ? P_ERRO  : P_SKIP;
            P_ERRO: p_state_q <= (rx_data_q == CH_R) ? P_ERROR : P_SKIP;
            default: p_state_q <= P_SKIP;
          endcase
        end
      end
    end
  end

  // ---------------- response timeout timer ----------------
  logic [TW-1:0] tmr_cnt_q, tmr_cnt_d;
  logic          tmr_armed_q, tmr_armed_d;
  logic          resp_timeout_q, resp_timeout_d;

  // A new command re-arms even if a result lands in the same cycle
  always_comb begin
    tmr_cnt_d      = tmr_cnt_q;
    tmr_armed_d    = tmr_armed_q;
    resp_timeout_d = 1'b0;
    if (cmd_sent) begin
      tmr_cnt_d   = '0;
      tmr_armed_d = 1'b1;
    end else if (resp_ok_q || resp_err_q || resp_prompt_q) begin
      tmr_cnt_d   = '0;
      tmr_armed_d = 1'b0;
    end else if (tmr_armed_q) begin
      if (tmr_cnt_q == TMO_M1) begin
        resp_timeout_d = 1'b1;
        tmr_armed_d    = 1'b0;
        tmr_cnt_d      = '0;
      end else begin
        tmr_cnt_d = tmr_cnt_q + 1'b1;
      end
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_cnt_q      <= '0;
      tmr_armed_q    <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      tmr_cnt_q      <= tmr_cnt_d;
      tmr_armed_q    <= tmr_armed_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_err    = frame_err_q;
  assign rx_busy      = rx_busy_q;
  assign resp_ok      = resp_ok_q;
  assign resp_err     = resp_err_q;
  assign resp_prompt  = resp_prompt_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_gsm_resp_rx.sv
// Directed testbench for gsm_resp_rx at CLKS_PER_BIT=16, TIMEOUT_CLKS=1000.
module tb_gsm_resp_rx;

  localparam int CPB = 16;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_rx = 1'b1;
  logic       cmd_sent = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, rx_busy;
  logic       resp_ok, resp_err, resp_prompt, resp_timeout;

  gsm_resp_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .line_rx(line_rx), .cmd_sent(cmd_sent),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy),
    .resp_ok(resp_ok), .resp_err(resp_err), .resp_prompt(resp_prompt),
    .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Event monitor state (written only by the monitor below)
  int n_valid = 0, n_ferr = 0, n_ok = 0, n_err = 0, n_prompt = 0, n_to = 0, n_multi = 0;
  int last_cr_cyc = -1, last_gt_cyc = -1, last_ok_cyc = -1, last_err_cyc = -1, last_prompt_cyc = -1;
  logic [7:0] byte_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs half a cycle after the active edge; one line per event
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      byte_q.push_back(rx_data);
      if (rx_data == 8'h0D) last_cr_cyc = cyc;
      if (rx_data == 8'h3E) last_gt_cyc = cyc;
      $display("cycle %0d: rx byte 0x%02h", cyc, rx_data);
    end
    if (frame_err)    begin n_ferr++;  $display("cycle %0d: frame error", cyc); end
    if (resp_ok)      begin n_ok++;    last_ok_cyc = cyc;     $display("cycle %0d: resp_ok", cyc); end
    if (resp_err)     begin n_err++;   last_err_cyc = cyc;    $display("cycle %0d: resp_err", cyc); end
    if (resp_prompt)  begin n_prompt++; last_prompt_cyc = cyc; $display("cycle %0d: resp_prompt", cyc); end
    if (resp_timeout) begin n_to++;    $display("cycle %0d: resp_timeout", cyc); end
    if ((resp_ok && resp_err) || (resp_ok && resp_prompt) || (resp_err && resp_prompt) ||
        (rx_valid && frame_err)) n_multi++;
  end

  // Drive one 8N1 frame; called on a negedge and returns on a negedge (no idle gap)
  task automatic send_byte(input logic [7:0] b, input logic stop);
    line_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    line_rx = stop;
    repeat (CPB) @(negedge clk);
    line_rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if ({rx_valid, frame_err, rx_busy} !== 3'b000) begin fails++; $display("FAIL reset_rx_flags: got %b want 000", {rx_valid, frame_err, rx_busy}); end
    checks++; if ({resp_ok, resp_err, resp_prompt, resp_timeout} !== 4'b0000) begin fails++; $display("FAIL reset_resp: got %b want 0000", {resp_ok, resp_err, resp_prompt, resp_timeout}); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ok();
    int b0, v0, ok0, er0, pr0;
    logic [7:0] exp_b [4];
    exp_b = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    b0 = byte_q.size(); v0 = n_valid; ok0 = n_ok; er0 = n_err; pr0 = n_prompt;
    send_str("OK\r\n");
    repeat (20) @(negedge clk);
    checks++; if (n_valid - v0 !== 4) begin fails++; $display("FAIL ok_byte_count: got %0d want 4", n_valid - v0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (byte_q.size() <= b0 + i) begin fails++; $display("FAIL ok_byte%0d: missing want %h", i, exp_b[i]); end
      else if (byte_q[b0 + i] !== exp_b[i]) begin fails++; $display("FAIL ok_byte%0d: got %h want %h", i, byte_q[b0 + i], exp_b[i]); end
    end
    checks++; if (n_ok - ok0 !== 1) begin fails++; $display("FAIL ok_pulse_count: got %0d want 1", n_ok - ok0); end
    checks++; if (last_ok_cyc - last_cr_cyc !== 1) begin fails++; $display("FAIL ok_latency: got %0d want 1", last_ok_cyc - last_cr_cyc); end
    checks++; if ((n_err - er0) + (n_prompt - pr0) !== 0) begin fails++; $display("FAIL ok_other_pulses: got %0d want 0", (n_err - er0) + (n_prompt - pr0)); end
  endtask

  task automatic test_echo_error();
    int ok0, er0, pr0;
    ok0 = n_ok; er0 = n_err; pr0 = n_prompt;
    send_str("AT\r\n");
    repeat (20) @(negedge clk);
    checks++; if ((n_ok - ok0) + (n_err - er0) + (n_prompt - pr0) !== 0) begin fails++; $display("FAIL echo_no_pulse: got %0d want 0", (n_ok - ok0) + (n_err - er0)); end
    send_str("ERROR\r\n");
    repeat (20) @(negedge clk);
    checks++; if (n_err - er0 !== 1) begin fails++; $display("FAIL err_pulse_count: got %0d want 1", n_err - er0); end
    checks++; if (last_err_cyc - last_cr_cyc !== 1) begin fails++; $display("FAIL err_latency: got %0d want 1", last_err_cyc - last_cr_cyc); end
    send_str("OKX\r");
    repeat (20) @(negedge clk);
    checks++; if (n_ok - ok0 !== 0) begin fails++; $display("FAIL okx_no_ok: got %0d want 0", n_ok - ok0); end
    checks++; if (n_prompt - pr0 !== 0) begin fails++; $display("FAIL echo_no_prompt: got %0d want 0", n_prompt - pr0); end
  endtask

  task automatic test_prompt();
    int pr0;
    pr0 = n_prompt;
    send_str("\r\n> ");
    repeat (20) @(negedge clk);
    checks++; if (n_prompt - pr0 !== 1) begin fails++; $display("FAIL prompt_count: got %0d want 1", n_prompt - pr0); end
    checks++; if (last_prompt_cyc - last_gt_cyc !== 1) begin fails++; $display("FAIL prompt_latency: got %0d want 1", last_prompt_cyc - last_gt_cyc); end
    send_str("X>\r");
    repeat (20) @(negedge clk);
    checks++; if (n_prompt - pr0 !== 1) begin fails++; $display("FAIL prompt_not_first: got %0d want 1", n_prompt - pr0); end
  endtask

  task automatic test_frame_err();
    int v0, f0, ok0;
    v0 = n_valid; f0 = n_ferr; ok0 = n_ok;
    send_byte(8'h41, 1'b0);
    line_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    line_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++; if (n_ferr - f0 !== 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
    checks++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL ferr_no_valid: got %0d want 0", n_valid - v0); end
    checks++; if (rx_data !== 8'h0D) begin fails++; $display("FAIL ferr_data_held: got %h want 0d", rx_data); end
    send_str("OK\r");
    repeat (20) @(negedge clk);
    checks++; if (n_ok - ok0 !== 1) begin fails++; $display("FAIL ok_after_ferr: got %0d want 1", n_ok - ok0); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    line_rx = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b want 1", rx_busy); end
    line_rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", rx_busy); end
    checks++; if ((n_valid - v0) + (n_ferr - f0) !== 0) begin fails++; $display("FAIL glitch_output: got %0d want 0", (n_valid - v0) + (n_ferr - f0)); end
  endtask

  task automatic test_timeout();
    int t0, t1, to0, ok0;
    bit seen;
    // No traffic: timeout must follow cmd_sent by TMO cycles (one more counting both high cycles)
    @(negedge clk); cmd_sent = 1'b1; t0 = cyc;
    @(negedge clk); cmd_sent = 1'b0;
    seen = 0; t1 = 0;
    for (int i = 0; i < TMO + 200 && !seen; i++) begin
      @(negedge clk);
      if (resp_timeout) begin seen = 1; t1 = cyc; end
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL timeout_idle: no pulse within %0d cycles want %0d", TMO + 200, TMO); end
    else if (t1 - t0 < TMO || t1 - t0 > TMO + 1) begin fails++; $display("FAIL timeout_idle: got %0d cycles want %0d", t1 - t0, TMO); end
    repeat (10) @(negedge clk);
    // Result within the window cancels the timeout
    to0 = n_to; ok0 = n_ok;
    cmd_sent = 1'b1;
    @(negedge clk); cmd_sent = 1'b0;
    send_str("OK\r");
    repeat (TMO + 200) @(negedge clk);
    checks++; if (n_ok - ok0 !== 1) begin fails++; $display("FAIL timeout_ok_seen: got %0d want 1", n_ok - ok0); end
    checks++; if (n_to - to0 !== 0) begin fails++; $display("FAIL timeout_cancelled: got %0d want 0", n_to - to0); end
    // cmd_sent in the same cycle as resp_ok re-arms the timer
    send_str("OK");
    seen = 0; t0 = 0;
    fork
      send_byte(8'h0D, 1'b1);
      begin
        for (int i = 0; i < 12 * CPB && !seen; i++) begin
          @(negedge clk);
          if (rx_valid && rx_data == 8'h0D) seen = 1;
        end
        if (seen) begin
          @(negedge clk);
          checks++; if (resp_ok !== 1'b1) begin fails++; $display("FAIL coincide_ok: got %b want 1", resp_ok); end
          cmd_sent = 1'b1; t0 = cyc;
          @(negedge clk); cmd_sent = 1'b0;
        end
      end
    join
    checks++;
    if (!seen) begin fails++; $display("FAIL coincide_cr: no 0d byte want 0d"); end
    else begin
      seen = 0; t1 = 0;
      for (int i = 0; i < TMO + 200 && !seen; i++) begin
        @(negedge clk);
        if (resp_timeout) begin seen = 1; t1 = cyc; end
      end
      if (!seen) begin fails++; $display("FAIL coincide_timeout: no pulse want %0d cycles", TMO); end
      else if (t1 - t0 < TMO || t1 - t0 > TMO + 1) begin fails++; $display("FAIL coincide_timeout: got %0d cycles want %0d", t1 - t0, TMO); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_byte();
    int v0, f0, ok0;
    // Partial 0x55: start, bits 0..1, then reset halfway through bit 2
    line_rx = 1'b0; repeat (CPB) @(negedge clk);
    line_rx = 1'b1; repeat (CPB) @(negedge clk);
    line_rx = 1'b0; repeat (CPB) @(negedge clk);
    line_rx = 1'b1; repeat (CPB / 2) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", rx_busy); end
    v0 = n_valid; f0 = n_ferr; ok0 = n_ok;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({rx_busy, rx_valid, frame_err} !== 3'b000) begin fails++; $display("FAIL mid_rst_flags: got %b want 000", {rx_busy, rx_valid, frame_err}); end
    checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL mid_rst_data: got %h want 00", rx_data); end
    repeat (12 * CPB) @(negedge clk);
    checks++; if ((n_valid - v0) + (n_ferr - f0) !== 0) begin fails++; $display("FAIL mid_no_partial: got %0d want 0", (n_valid - v0) + (n_ferr - f0)); end
    send_str("OK\r");
    repeat (20) @(negedge clk);
    checks++; if (n_valid - v0 !== 3) begin fails++; $display("FAIL mid_new_bytes: got %0d want 3", n_valid - v0); end
    checks++; if (n_ok - ok0 !== 1) begin fails++; $display("FAIL mid_ok: got %0d want 1", n_ok - ok0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ok();
    test_echo_error();
    test_prompt();
    test_frame_err();
    test_glitch();
    test_timeout();
    test_reset_mid_byte();
    checks++; if (n_multi !== 0) begin fails++; $display("FAIL exclusive_pulses: got %0d want 0", n_multi); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
